data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Byte-addressed, little-endian data memory for the RV32IM core's load/store stage.
- Supports byte, half-word and word stores with byte-lane masking.
- Loads are sign- or zero-extended to 32 bits.
- Writes are synchronous on the rising clock edge; reads are combinational from the current address and memory contents.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words stored. Must be a power of two.
- INIT_FILE, "" (empty): if non-empty, $readmemh image loaded at time 0 (simulation only). Reset still clears to zero.

Ports:
- clk  input  1  rising-edge clock for writes.
- rst_n  input  1  asynchronous active-low reset.
- a  input  32  byte address.
- wd  input  32  store data; stores take the low-order bytes.
- data_size  input  2  access size: 00 byte, 01 half-word, 10 word, 11 treated as word.
- data_unsigned  input  1  load extension: 0 sign-extend, 1 zero-extend.
- we  input  1  write enable.
- rd  output  32  load data, combinational.

Behaviour:
- Storage: DEPTH_WORDS x 32-bit register array.
- Word index = a[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS bytes.
- Alignment: accesses are aligned down by dropping low bits.
  - Byte: lane = a[1:0].
  - Half-word: uses a[1]; a[0] is ignored.
  - Word: ignores a[1:0].
- Reset: while rst_n = 0, every word is asynchronously cleared to 0x00000000 and writes are blocked.
  - rd therefore reads 0 during reset.
  - Deassertion takes effect immediately; the first write can occur on the next rising clk edge.
- Write: on posedge clk with rst_n = 1 and we = 1, only the addressed lanes are updated; other lanes keep their values.
  - Byte: wd[7:0] written to lane a[1:0].
  - Half-word: wd[15:0] written to lanes {2*a[1]+1, 2*a[1]}.
  - Word: wd written to all 4 lanes.
- Read: rd is combinational from a, data_size, data_unsigned and array contents.
  - Byte: the addressed byte, extended from bit 7.
  - Half-word: the addressed half, extended from bit 15.
  - Word: the full word; data_unsigned has no effect.
- Timing: a write on edge N is visible on rd immediately after edge N (same cycle, settled before the following negedge). No read latency.
- Simultaneous we with changing a: the write uses a and wd sampled at the rising edge.
- we = 0: memory holds; rd tracks the inputs.

Optional Feature:
- Macro: DATA_MEMORY_MISALIGN_CHECK_EN.
- When defined:
  - Extra output port misaligned (1 bit, combinational).
  - misaligned = 1 for a half-word access with a[0] = 1, or a word access (10/11) with a[1:0] != 0.
  - When misaligned = 1, the write is suppressed even if we = 1, and rd = 0x00000000.
- When not defined: no extra port; misaligned accesses are silently aligned down as above.

Test Plan:
- Reset then read: pulse rst_n low mid-cycle, then read word @0x0 and @0x3FC -> rd = 0x00000000; writes attempted during reset have no effect.
- Word access: word write 0xDEADBEEF @0x0 with we = 1 -> rd = 0xDEADBEEF after the edge. With we = 0 -> still 0xDEADBEEF.
- Byte access: byte write wd = 0x000000A5 @0x4.
  - Signed read -> 0xFFFFFFA5.
  - Unsigned read -> 0x000000A5.
  - Word read @0x4 -> 0x000000A5 (other lanes still 0).
- Half-word access: half write wd = 0x00008001 @0x8.
  - Signed read -> 0xFFFF8001.
  - Unsigned read -> 0x00008001.
  - Half write 0x1234 @0xA, then word read @0x8 -> 0x12348001.
- Lane masking: word 0x11223344 @0x10, then byte write 0xFF @0x12.
  - Word read -> 0x11FF3344.
  - Signed byte read @0x13 -> 0x00000011.
- Wrap and alignment: word write 0xCAFEF00D @(4*DEPTH_WORDS) -> word read @0x0 = 0xCAFEF00D. Half read @0x1 returns the half @0x0 (macro off) or misaligned = 1 and rd = 0 (macro on).

Source files
------------

// File: rtl/data_memory.sv
// Byte-addressed little-endian data memory with byte/half/word lane-masked stores and sign/zero-extended loads.
// Latency: stores commit on the rising clk edge; loads are combinational (zero cycles).
// Backpressure: none, an access is accepted every cycle. Optional DATA_MEMORY_MISALIGN_CHECK_EN adds a misaligned flag.
module data_memory #(
  parameter int    DEPTH_WORDS = 256,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic [1:0]  data_size,
  input  logic        data_unsigned,
  input  logic        we,
`ifdef DATA_MEMORY_MISALIGN_CHECK_EN
  output logic        misaligned,
`endif
  output logic [31:0] rd
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // Reset clears the whole array, so a preload image would never be observable.
  localparam bit unused_init_file = (INIT_FILE != "");

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [3:0]    lane_be;
  logic [31:0]   lane_dat;
  logic [31:0]   word_dat;
  logic [7:0]    byte_dat;
  logic [15:0]   half_dat;
  logic [31:0]   load_dat;
  logic          mis;
  logic          wr_en;
  logic          unused_addr_bits;

  assign idx              = a[AW+1:2];
  assign unused_addr_bits = ^a[31:AW+2];

`ifdef DATA_MEMORY_MISALIGN_CHECK_EN
  assign mis        = ((data_size == 2'b01) && a[0]) ||
                      (data_size[1] && (a[1:0] != 2'b00));
  assign misaligned = mis;
`else
  assign mis        = 1'b0;
`endif

  assign wr_en = we && !mis;

  // Replicate store data across lanes so each byte enable picks its own slice.
  always_comb begin
    lane_be  = 4'b1111;
    lane_dat = wd;
    case (data_size)
      2'b00: begin
        lane_be  = 4'b0001 << a[1:0];
        lane_dat = {4{wd[7:0]}};
      end
      2'b01: begin
        lane_be  = a[1] ? 4'b1100 : 4'b0011;
        lane_dat = {2{wd[15:0]}};
      end
      default: begin
        lane_be  = 4'b1111;
        lane_dat = wd;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      for (int l = 0; l < 4; l++) begin
        if (lane_be[l]) begin
          mem[idx][8*l +: 8] <= lane_dat[8*l +: 8];
        end
      end
    end
  end

  always_comb begin
    word_dat = mem[idx];
    byte_dat = word_dat[8*a[1:0] +: 8];
    half_dat = word_dat[16*a[1] +: 16];
    case (data_size)
      2'b00:   load_dat = data_unsigned ? {24'h0, byte_dat} : {{24{byte_dat[7]}}, byte_dat};
      2'b01:   load_dat = data_unsigned ? {16'h0, half_dat} : {{16{half_dat[15]}}, half_dat};
      default: load_dat = word_dat;
    endcase
    rd = mis ? 32'h0 : load_dat;
  end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboarded bench for data_memory: directed test-plan vectors plus random traffic against a byte-array model.
module tb_data_memory;

  localparam int DEPTH = 256;
  localparam int MEMB  = 4 * DEPTH;
`ifdef DATA_MEMORY_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] wd;
  logic [1:0]  data_size;
  logic        data_unsigned;
  logic        we;
  logic [31:0] rd;
`ifdef DATA_MEMORY_MISALIGN_CHECK_EN
  logic        misaligned;
`endif

  data_memory #(.DEPTH_WORDS(DEPTH), .INIT_FILE("")) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .a             (a),
    .wd            (wd),
    .data_size     (data_size),
    .data_unsigned (data_unsigned),
    .we            (we),
`ifdef DATA_MEMORY_MISALIGN_CHECK_EN
    .misaligned    (misaligned),
`endif
    .rd            (rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    string       name;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem_b [MEMB];
  int         checks   = 0;
  int         failures = 0;

  // Reference model: a flat byte array addressed modulo its size.
  function automatic logic model_mis(input logic [31:0] addr, input logic [1:0] sz);
    if (!MIS_EN) return 1'b0;
    if (sz == 2'b01) return (addr % 2) != 0;
    if (sz >= 2'b10) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [1:0] sz,
                                             input logic uns);
    int unsigned b;
    int unsigned base;
    logic [15:0] h;
    logic [7:0]  by;
    b = addr % MEMB;
    if (model_mis(addr, sz)) return 32'h0;
    if (sz == 2'b00) begin
      by = mem_b[b];
      return uns ? {24'h0, by} : {{24{by[7]}}, by};
    end else if (sz == 2'b01) begin
      base = b - (b % 2);
      h = {mem_b[base+1], mem_b[base]};
      return uns ? {16'h0, h} : {{16{h[15]}}, h};
    end
    base = b - (b % 4);
    return {mem_b[base+3], mem_b[base+2], mem_b[base+1], mem_b[base]};
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] dat, input logic [1:0] sz);
    int unsigned b;
    int unsigned base;
    b = addr % MEMB;
    if (model_mis(addr, sz)) return;
    if (sz == 2'b00) begin
      mem_b[b] = dat[7:0];
    end else if (sz == 2'b01) begin
      base = b - (b % 2);
      mem_b[base]   = dat[7:0];
      mem_b[base+1] = dat[15:8];
    end else begin
      base = b - (b % 4);
      for (int k = 0; k < 4; k++) mem_b[base+k] = dat[8*k +: 8];
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < MEMB; i++) mem_b[i] = 8'h00;
  endtask

  task automatic push_exp(input logic [31:0] want, input logic mis, input string name);
    exp_t e;
    e.rd   = want;
    e.mis  = mis;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // One access per cycle: the read is checked before the edge that commits the write.
  task automatic op(input logic [31:0] addr, input logic [31:0] dat, input logic [1:0] sz,
                    input logic uns, input logic wen, input logic [31:0] want,
                    input bit has_want, input string name);
    @(posedge clk);
    #1;
    a             = addr;
    wd            = dat;
    data_size     = sz;
    data_unsigned = uns;
    we            = wen;
    push_exp(has_want ? want : model_read(addr, sz, uns), model_mis(addr, sz), name);
    if (wen) model_write(addr, dat, sz);
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_clear();
    a = 32'h0; wd = 32'h5555_5555; data_size = 2'b10; data_unsigned = 1'b0; we = 1'b1;
    push_exp(32'h0, 1'b0, "rst_rd_0x0");
    @(posedge clk);
    #1;
    a = 32'h3FC;
    push_exp(32'h0, 1'b0, "rst_rd_0x3fc");
    @(posedge clk);
    #1;
    a  = 32'h0;
    we = 1'b0;
    push_exp(32'h0, 1'b0, "rst_wr_blocked");
    #2 rst_n = 1'b1;
  endtask

  // Monitor: rd is combinational, so every queued expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (rd !== e.rd) begin
        failures++;
        $display("FAIL %s: rd=%08h expected=%08h (a=%08h size=%0d uns=%0b)",
                 e.name, rd, e.rd, a, data_size, data_unsigned);
      end
`ifdef DATA_MEMORY_MISALIGN_CHECK_EN
      checks++;
      if (misaligned !== e.mis) begin
        failures++;
        $display("FAIL %s_mis: misaligned=%0b expected=%0b", e.name, misaligned, e.mis);
      end
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a = 32'h0; wd = 32'h0; data_size = 2'b10; data_unsigned = 1'b0; we = 1'b0;
    model_clear();
    #1;
    a = 32'h3FC;
    push_exp(32'h0, 1'b0, "reset_state");
    #11 rst_n = 1'b1;

    op(32'h0,  32'hDEAD_BEEF, 2'b10, 1'b0, 1'b1, 32'h0, 1'b0, "word_wr");
    op(32'h0,  32'h0,         2'b10, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, "word_rd");
    op(32'h0,  32'h0,         2'b10, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, "word_rd_uns");
    op(32'h4,  32'h0000_00A5, 2'b00, 1'b0, 1'b1, 32'h0, 1'b0, "byte_wr");
    op(32'h4,  32'h0,         2'b00, 1'b0, 1'b0, 32'hFFFF_FFA5, 1'b1, "byte_rd_s");
    op(32'h4,  32'h0,         2'b00, 1'b1, 1'b0, 32'h0000_00A5, 1'b1, "byte_rd_u");
    op(32'h4,  32'h0,         2'b10, 1'b0, 1'b0, 32'h0000_00A5, 1'b1, "byte_word_rd");
    op(32'h8,  32'h0000_8001, 2'b01, 1'b0, 1'b1, 32'h0, 1'b0, "half_wr");
    op(32'h8,  32'h0,         2'b01, 1'b0, 1'b0, 32'hFFFF_8001, 1'b1, "half_rd_s");
    op(32'h8,  32'h0,         2'b01, 1'b1, 1'b0, 32'h0000_8001, 1'b1, "half_rd_u");
    op(32'hA,  32'h0000_1234, 2'b01, 1'b0, 1'b1, 32'h0, 1'b0, "half_hi_wr");
    op(32'h8,  32'h0,         2'b10, 1'b0, 1'b0, 32'h1234_8001, 1'b1, "half_word_rd");
    op(32'h10, 32'h1122_3344, 2'b10, 1'b0, 1'b1, 32'h0, 1'b0, "mask_word_wr");
    op(32'h12, 32'h0000_00FF, 2'b00, 1'b0, 1'b1, 32'h0000_0022, 1'b1, "mask_byte_wr");
    op(32'h10, 32'h0,         2'b10, 1'b0, 1'b0, 32'h11FF_3344, 1'b1, "mask_word_rd");
    op(32'h13, 32'h0,         2'b00, 1'b0, 1'b0, 32'h0000_0011, 1'b1, "mask_byte_rd");
    op(MEMB,   32'hCAFE_F00D, 2'b10, 1'b0, 1'b1, 32'h0, 1'b0, "wrap_wr");
    op(32'h0,  32'h0,         2'b10, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b1, "wrap_rd");
    op(32'h1,  32'h0,         2'b01, 1'b0, 1'b0, MIS_EN ? 32'h0 : 32'hFFFF_F00D, 1'b1, "misalign_half_rd");
    op(32'h2,  32'h1111_1111, 2'b10, 1'b0, 1'b1, 32'h0, 1'b0, "misalign_word_wr");
    op(32'h0,  32'h0,         2'b10, 1'b0, 1'b0, MIS_EN ? 32'hCAFE_F00D : 32'h1111_1111, 1'b1, "misalign_word_rd");

    reset_pulse();
    op(32'h3FC, 32'h0, 2'b10, 1'b0, 1'b0, 32'h0, 1'b1, "post_rst_0x3fc");
    op(32'h0,   32'h0, 2'b10, 1'b0, 1'b0, 32'h0, 1'b1, "post_rst_0x0");

    for (int n = 0; n < 400; n++) begin
      logic [31:0] ra;
      ra = $urandom_range(0, 127) + ($urandom_range(0, 3) * MEMB);
      op(ra, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), 32'h0, 1'b0, "random");
    end

    @(posedge clk);
    #1 we = 1'b0;
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) @(posedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
